rotary_accum: RTL and testbench

- Front-panel quadrature decoder for the frequency dial; upstream stage feeding the command dispatcher's `fq_change`/`fq_valid` inputs.
- Synchronises and debounces the mechanical CK/DT contacts and decodes quarter-steps into detents.
- Keeps a signed saturating detent count since the last read; hands it over and clears it on a level-based read handshake.

---
 rtl/rotary_pkg.sv | 49 ++++
 rtl/debounce_sync.sv | 48 ++++
 rtl/rotary_accum.sv | 146 ++++++++++++++
 tb/tb_rotary_accum.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary dial decoder.
//   hs_state_t  : read handshake states (IDLE, HOLD)
//   QS_W        : width of the signed quarter-step counter (holds +/-4)
//   quad_step() : quadrature transition -> signed quarter-step (-1, 0, +1)
//   sat_add()   : signed add of a detent delta, clamped to a given width
package rotary_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hs_state_t;

    localparam int QS_W = 4;

    // Gray-code walk 00->10->11->01->00 is clockwise (+1); the reverse walk
    // is -1. No change and two-bit jumps (contact bounce that got past the
    // debouncer, or a missed state) both decode to 0.
    function automatic logic signed [1:0] quad_step(input logic [1:0] prev_ab,
                                                    input logic [1:0] cur_ab);
        logic signed [1:0] step;
        case ({prev_ab, cur_ab})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = 2'sb01;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step = 2'sb11;
            default:                                step = 2'sb00;
        endcase
        return step;
    endfunction

    // Add a -1/0/+1 delta to a value already known to fit in 'width' bits
    // and clamp to that width's two's-complement range. Works on 32 bits so
    // one function serves every OUT_WIDTH up to 31.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [1:0]  d,
                                                   input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] s;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        s  = a + 32'(d);
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Synchroniser plus debouncer for one mechanical contact.
//   aclk  : system clock
//   reset : asynchronous active-high reset
//   din   : raw contact level, asynchronous to aclk
//   dout  : debounced level; follows din once the synchronised value has
//           differed from it for DEBOUNCE_CYCLES consecutive cycles
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic aclk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   db_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   sync_out;

    assign sync_out = sync_reg[SYNC_STAGES-1];
    assign dout     = db_reg;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
            db_reg   <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            // Any cycle where the contact agrees with the accepted level
            // restarts the qualification window, so short glitches vanish.
            if (sync_out == db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                db_reg  <= sync_out;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rotary_accum.sv
// Quadrature decoder and detent accumulator for the front-panel frequency dial.
//   aclk        : system clock, all logic on posedge
//   reset       : asynchronous active-high reset
//   ck, dt      : encoder contacts A/B, asynchronous to aclk
//   read_enable : level request from the consumer, held until out_valid
//   out         : signed detents since the previous read (two's complement)
//   out_valid   : out is valid; stays high while read_enable stays high
module rotary_accum #(
    parameter int OUT_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES  = 1000,
    parameter int STEPS_PER_DETENT = 4,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic                        ck,
    input  logic                        dt,
    input  logic                        read_enable,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        out_valid
);

    import rotary_pkg::*;

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0]      FILL_DONE = FILL_W'(SYNC_STAGES);
    localparam logic signed [QS_W-1:0] QS_MAX    = QS_W'(STEPS_PER_DETENT);

    logic [1:0] pin_ab;
    logic [1:0] cur_ab;

    assign pin_ab = {ck, dt};

    // One synchroniser/debouncer per contact; bit 1 = ck (a), bit 0 = dt (b).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_contact
            debounce_sync #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .aclk (aclk),
                .reset(reset),
                .din  (pin_ab[gi]),
                .dout (cur_ab[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------
    // Priming and quadrature decode
    // ---------------------------------------------------------------
    logic [FILL_W-1:0]      fill_reg;
    logic                   primed_reg;
    logic [1:0]             prev_ab_reg;
    logic signed [QS_W-1:0] qs_reg;
    logic signed [QS_W-1:0] qs_sum;
    logic signed [QS_W-1:0] qs_next;
    logic signed [1:0]      step;
    logic signed [1:0]      delta;

    // Until primed, prev_ab holds its reset value, which need not match the
    // contacts; decoding against it could invent a step.
    assign step   = primed_reg ? quad_step(prev_ab_reg, cur_ab) : 2'sb00;
    assign qs_sum = qs_reg + QS_W'(step);

    always_comb begin
        delta   = 2'sb00;
        qs_next = qs_sum;
        if (qs_sum == QS_MAX) begin
            delta   = 2'sb01;
            qs_next = '0;
        end else if (qs_sum == -QS_MAX) begin
            delta   = 2'sb11;
            qs_next = '0;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            fill_reg    <= '0;
            primed_reg  <= 1'b0;
            prev_ab_reg <= 2'b00;
            qs_reg      <= '0;
        end else begin
            if (fill_reg != FILL_DONE) begin
                fill_reg <= fill_reg + FILL_W'(1);
            end
            if (primed_reg) begin
                prev_ab_reg <= cur_ab;
                qs_reg      <= qs_next;
            end else if (fill_reg == FILL_DONE) begin
                prev_ab_reg <= cur_ab;
                primed_reg  <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Accumulator and read handshake
    // ---------------------------------------------------------------
    hs_state_t                  state_reg;
    logic signed [OUT_WIDTH-1:0] acc_reg;
    logic signed [OUT_WIDTH-1:0] acc_next;
    logic signed [OUT_WIDTH-1:0] out_reg;
    logic                        out_valid_reg;
    logic signed [31:0]          acc_sum32;

    assign acc_sum32 = sat_add(32'(acc_reg), delta, OUT_WIDTH);
    assign acc_next  = acc_sum32[OUT_WIDTH-1:0];

    assign out       = out_reg;
    assign out_valid = out_valid_reg;

    // A read hands over acc_next rather than acc_reg so a detent decoded in
    // the same cycle is neither lost nor counted twice; the accumulator
    // restarts from zero and keeps counting while the result is held.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (read_enable) begin
                        out_reg       <= acc_next;
                        acc_reg       <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= HOLD;
                    end else begin
                        acc_reg <= acc_next;
                    end
                end
                HOLD: begin
                    acc_reg <= acc_next;
                    if (!read_enable) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotary_accum.sv
// Directed testbench for rotary_accum with DEBOUNCE_CYCLES=4,
// STEPS_PER_DETENT=4, OUT_WIDTH=8, SYNC_STAGES=2.
module tb_rotary_accum;

    logic              aclk;
    logic              reset;
    logic              ck;
    logic              dt;
    logic              read_enable;
    logic signed [7:0] out;
    logic              out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    rotary_accum #(
        .OUT_WIDTH       (8),
        .DEBOUNCE_CYCLES (4),
        .STEPS_PER_DETENT(4),
        .SYNC_STAGES     (2)
    ) dut (
        .aclk       (aclk),
        .reset      (reset),
        .ck         (ck),
        .dt         (dt),
        .read_enable(read_enable),
        .out        (out),
        .out_valid  (out_valid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int n1;
        bit d1_cw;
        int glitches;
        int n2;
        bit d2_cw;
        int exp_out;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // All pin tasks start and end at #1 after a rising edge.
    task automatic set_pins(input logic a, input logic b, input int hold);
        ck = a;
        dt = b;
        repeat (hold) @(posedge aclk);
        #1;
    endtask

    task automatic detent(input bit cw);
        if (cw) begin
            set_pins(1'b1, 1'b0, 10);
            set_pins(1'b1, 1'b1, 10);
            set_pins(1'b0, 1'b1, 10);
            set_pins(1'b0, 1'b0, 10);
        end else begin
            set_pins(1'b0, 1'b1, 10);
            set_pins(1'b1, 1'b1, 10);
            set_pins(1'b1, 1'b0, 10);
            set_pins(1'b0, 1'b0, 10);
        end
    endtask

    // ck high for 3 cycles: one short of the debounce window.
    task automatic glitch();
        set_pins(1'b1, dt, 3);
        set_pins(1'b0, dt, 5);
    endtask

    // Raise read_enable; out_valid must be up one cycle later. Ends at negedge.
    task automatic start_read(input string name, input int exp);
        read_enable = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        $display("[TB] read %s: out=%0d out_valid=%0b (expected %0d)", name, out, out_valid, exp);
        check({name, ".valid"}, out_valid, 1);
        check({name, ".out"}, out, exp);
    endtask

    // Drop read_enable; out_valid falls one cycle later while out is retained.
    task automatic end_read(input string name, input int exp);
        @(posedge aclk);
        #1 read_enable = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check({name, ".drop_valid"}, out_valid, 0);
        check({name, ".retain"}, out, exp);
        @(posedge aclk);
        #1;
    endtask

    task automatic do_read(input string name, input int exp);
        start_read(name, exp);
        end_read(name, exp);
    endtask

    initial begin
        vecs[0] = '{3,   1'b1, 0,  0, 1'b1, 3};
        vecs[1] = '{0,   1'b1, 0,  0, 1'b1, 0};
        vecs[2] = '{2,   1'b0, 0,  1, 1'b1, -1};
        vecs[3] = '{1,   1'b1, 20, 0, 1'b1, 1};
        vecs[4] = '{1,   1'b1, 20, 1, 1'b1, 2};
        vecs[5] = '{130, 1'b1, 0,  0, 1'b1, 127};
        vecs[6] = '{260, 1'b0, 0,  0, 1'b1, -128};
        vecs[7] = '{0,   1'b1, 0,  0, 1'b1, 0};

        reset       = 1'b1;
        ck          = 1'b0;
        dt          = 1'b0;
        read_enable = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset.out", out, 0);
        check("reset.valid", out_valid, 0);
        @(posedge aclk);
        #1 reset = 1'b0;
        repeat (10) @(posedge aclk);
        #1;

        // Table-driven detent sequences, each followed by a read.
        for (int i = 0; i < NV; i++) begin
            repeat (vecs[i].n1) detent(vecs[i].d1_cw);
            repeat (vecs[i].glitches) glitch();
            repeat (vecs[i].n2) detent(vecs[i].d2_cw);
            do_read($sformatf("vec%0d", i), vecs[i].exp_out);
        end

        // Final detent edge reaches the decoder in the same cycle the read is
        // sampled: pin change after edge k, debounced at edge k+6, counted at k+7.
        detent(1'b1);
        detent(1'b1);
        set_pins(1'b1, 1'b0, 10);
        set_pins(1'b1, 1'b1, 10);
        set_pins(1'b0, 1'b1, 10);
        ck = 1'b0;
        dt = 1'b0;
        repeat (6) @(posedge aclk);
        #1;
        start_read("same_cycle", 3);
        end_read("same_cycle", 3);
        do_read("after_same_cycle", 0);

        // Detent completed while the previous result is being held.
        start_read("hold_pre", 0);
        @(posedge aclk);
        #1;
        detent(1'b1);
        check("hold.valid_stable", out_valid, 1);
        check("hold.out_stable", out, 0);
        end_read("hold_pre", 0);
        do_read("hold_detent", 1);

        // Async reset while holding +5, with pins left at 11 (qs mid-detent).
        repeat (5) detent(1'b1);
        set_pins(1'b1, 1'b0, 10);
        set_pins(1'b1, 1'b1, 10);
        start_read("pre_reset", 5);
        #2 reset = 1'b1;
        #1;
        check("async_reset.valid", out_valid, 0);
        check("async_reset.out", out, 0);
        read_enable = 1'b0;
        repeat (3) @(posedge aclk);
        #1 reset = 1'b0;
        repeat (20) @(posedge aclk);
        #1;
        do_read("post_reset", 0);

        // Counting resumes cleanly from 11 after re-priming.
        set_pins(1'b0, 1'b1, 10);
        set_pins(1'b0, 1'b0, 10);
        set_pins(1'b1, 1'b0, 10);
        set_pins(1'b1, 1'b1, 10);
        do_read("resume", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
